// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word width, RAS depth default and address type
package mips_pkg;
    localparam int WORD_W        = 32;
    localparam int RAS_DEPTH_DEF = 8;

    typedef logic [WORD_W-1:0] addr_t;
endpackage

// File: rtl/ras_mem.sv
// rtl/ras_mem.sv - return-address storage: synchronous write, asynchronous read, no reset
module ras_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);
    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address stack controller: circular LIFO, registered top, occupancy and flags
module ras_ctrl
    import mips_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int AW    = WORD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       top_valid,
    output logic [AW-1:0]              top_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int SPW = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);

    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_top;
    logic           r_top_valid;
    logic           r_ovf;
    logic           r_udf;

    logic           w_we;
    logic [SPW-1:0] w_waddr;
    logic [SPW-1:0] w_sp_m1;
    logic [SPW-1:0] w_sp_m2;
    logic [AW-1:0]  w_rdata;
    logic [SPW-1:0] w_sp_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [AW-1:0]  w_top_nxt;
    logic           w_ovf;
    logic           w_udf;
    logic           w_empty;
    logic           w_full;

    assign w_sp_m1 = r_sp - SPW'(1);
    assign w_sp_m2 = r_sp - SPW'(2);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // The read port always looks at the entry just below the top, which becomes the top after a pop.
    ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (push_addr),
        .raddr (w_sp_m2),
        .rdata (w_rdata)
    );

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_sp;
        w_sp_nxt  = r_sp;
        w_cnt_nxt = r_count;
        w_top_nxt = r_top;
        w_ovf     = 1'b0;
        w_udf     = 1'b0;
        if (flush) begin
            w_cnt_nxt = '0;
        end else if (push && pop && !w_empty) begin
            w_we      = 1'b1;
            w_waddr   = w_sp_m1;
            w_top_nxt = push_addr;
        end else if (push) begin
            w_we      = 1'b1;
            w_sp_nxt  = r_sp + SPW'(1);
            w_top_nxt = push_addr;
            if (w_full) begin
                w_ovf = 1'b1;
            end else begin
                w_cnt_nxt = r_count + CW'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_udf = 1'b1;
            end else begin
                w_sp_nxt  = w_sp_m1;
                w_cnt_nxt = r_count - CW'(1);
                // Popping the last entry leaves top_addr holding its old value.
                if (r_count > CW'(1)) begin
                    w_top_nxt = w_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_top       <= '0;
            r_top_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_count     <= w_cnt_nxt;
            r_top       <= w_top_nxt;
            r_top_valid <= (w_cnt_nxt != '0);
            r_ovf       <= w_ovf;
            r_udf       <= w_udf;
        end
    end

    assign top_valid = r_top_valid;
    assign top_addr  = r_top;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - directed and randomized bench for ras_ctrl against a queue-based stack model
module tb_ras_ctrl;
    import mips_pkg::*;

    localparam int DEPTH = RAS_DEPTH_DEF;
    localparam int AW    = WORD_W;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          push      = 1'b0;
    logic          pop       = 1'b0;
    logic          flush     = 1'b0;
    addr_t         push_addr = '0;
    logic          top_valid;
    addr_t         top_addr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int    n_total = 0;
    int    n_pass  = 0;
    addr_t q[$];
    addr_t m_top = '0;
    bit    m_ovf = 1'b0;
    bit    m_udf = 1'b0;

    always #5 clk = ~clk;

    ras_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .flush     (flush),
        .top_valid (top_valid),
        .top_addr  (top_addr),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input addr_t obs, input addr_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     addr_t'(count),     addr_t'(q.size()));
        chk({tag, ".top_valid"}, addr_t'(top_valid), addr_t'(q.size() != 0));
        chk({tag, ".top_addr"},  top_addr,           m_top);
        chk({tag, ".overflow"},  addr_t'(overflow),  addr_t'(m_ovf));
        chk({tag, ".underflow"}, addr_t'(underflow), addr_t'(m_udf));
    endtask

    // Stack semantics: bounded LIFO that drops its oldest entry when full.
    task automatic model(input bit p, input addr_t a, input bit po, input bit f);
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (f) begin
            q.delete();
        end else if (p && po && q.size() > 0) begin
            q[q.size()-1] = a;
            m_top = a;
        end else if (p) begin
            if (q.size() == DEPTH) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            q.push_back(a);
            m_top = a;
        end else if (po) begin
            if (q.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                void'(q.pop_back());
                if (q.size() > 0) m_top = q[q.size()-1];
            end
        end
    endtask

    task automatic cyc(input bit p, input addr_t a, input bit po, input bit f, input string tag);
        push      = p;
        push_addr = a;
        pop       = po;
        flush     = f;
        @(posedge clk);
        model(p, a, po, f);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b1, 32'h0040_0008, 1'b0, 1'b0, "basic_push1");
        cyc(1'b1, 32'h0040_0010, 1'b0, 1'b0, "basic_push2");
        cyc(1'b1, 32'h0040_0018, 1'b0, 1'b0, "basic_push3");
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, "basic_pop");

        for (int i = 1; i <= 9; i++) cyc(1'b1, addr_t'(32'h100 + i), 1'b0, 1'b0, "fill_push");
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0, "drain_pop");
        cyc(1'b0, '0, 1'b0, 1'b0, "after_underflow");

        cyc(1'b1, 32'h5, 1'b0, 1'b0, "repl_setup1");
        cyc(1'b1, 32'hA, 1'b0, 1'b0, "repl_setup2");
        cyc(1'b1, 32'hB, 1'b1, 1'b0, "replace_top");
        cyc(1'b0, '0, 1'b1, 1'b0, "repl_pop");
        cyc(1'b0, '0, 1'b1, 1'b0, "repl_empty");

        cyc(1'b1, 32'h77, 1'b1, 1'b0, "pushpop_empty");
        cyc(1'b0, '0, 1'b1, 1'b0, "pushpop_drain");

        for (int i = 0; i < 5; i++) cyc(1'b1, addr_t'(32'h200 + i), 1'b0, 1'b0, "flush_setup");
        cyc(1'b1, 32'h2FF, 1'b0, 1'b1, "flush_push");
        cyc(1'b1, 32'h300, 1'b0, 1'b0, "flush_next_push");

        for (int i = 0; i < 3; i++) cyc(1'b1, addr_t'(32'h400 + i), 1'b0, 1'b0, "arst_setup");
        push = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        m_top = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_all("arst_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h1234, 1'b0, 1'b0, "arst_first_push");
        cyc(1'b1, 32'h5678, 1'b0, 1'b0, "arst_second_push");
        cyc(1'b0, '0, 1'b1, 1'b0, "arst_pop");

        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 50, addr_t'($urandom), (r >= 35 && r < 95), (r >= 97), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address stack controller for the MIPS soft core's fetch stage. It captures the link address on every call (`jal`/`jalr`) and presents the predicted return target for `jr $ra` one cycle later. It manages a circular LIFO of return addresses, which is this block's datapath. It also reports occupancy and overflow/underflow events to the hazard/branch unit.

## Interface
Parameters:
- `DEPTH`, 8, number of stored return addresses; power of two, ≥2
- `AW`, 32, address width in bits

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `push`  in  1  call retired; store `push_addr`
- `push_addr`  in  AW  link address (PC+8, computed upstream)
- `pop`  in  1  `jr $ra` retired; remove top entry
- `flush`  in  1  pipeline flush / exception; empty the stack
- `top_valid`  out  1  `top_addr` holds a real entry
- `top_addr`  out  AW  registered predicted return address
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- `overflow`  out  1  one-cycle pulse: push dropped the oldest entry
- `underflow`  out  1  one-cycle pulse: pop on an empty stack

## Operation
- State:
  - write pointer `sp`, $clog2(DEPTH) bits, wraps modulo DEPTH
  - `count`, saturating at DEPTH
  - storage array, DEPTH × AW
- The top entry is at `sp-1` (mod DEPTH).
- Priority per cycle is flush > (push & pop) > push > pop.
- `flush`:
  - Sets `count`=0 and `top_valid`=0.
  - `sp` is unchanged.
  - No flags are raised; `push`/`pop` are ignored that cycle.
- `push` only:
  - Write `mem[sp]`, then `sp`+1.
  - If `count`<DEPTH, `count`+1.
  - Otherwise `count` stays at DEPTH and `overflow` pulses; the oldest entry is overwritten by the wrap.
- `pop` only:
  - If `count`>0: `sp`-1, `count`-1.
  - If `count`==0: no state change; `underflow` pulses.
- `push` & `pop` together (replace top):
  - If `count`>0, write `mem[sp-1]`; `sp` and `count` are unchanged.
  - If `count`==0, act as a plain push (`count`=1) with no underflow.
- Output update:
  - `top_addr` is loaded each cycle with the post-update top entry; on a push it takes the bypassed `push_addr`, not a memory readback.
  - `top_valid` = (post-update `count` ≠ 0).
  - When the stack becomes empty, `top_addr` holds its last value.
- Arithmetic:
  - Pointer arithmetic is unsigned modulo DEPTH.
  - `count` never exceeds DEPTH and never goes below 0.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `sp`=0, `count`=0, `top_valid`=0, `top_addr`=0, `overflow`=0, `underflow`=0.
  - Storage is not reset.
  - Deassertion is taken synchronously by the next edge.
- Latency:
  - Push on edge N → `top_addr`=`push_addr` and `top_valid`=1 after edge N.
  - Pop on edge N → new top visible after edge N.
  - This is single-cycle, back-to-back capable.
- `overflow` and `underflow` are high for exactly the cycle after the offending edge.
- Reset asserted mid-stream discards all entries immediately; the first push after reset lands in slot 0.
- Inputs are sampled only at the rising edge. No handshake back-pressure: every request is accepted.

## Structure
- The shared `mips_pkg` holds:
  - `WORD_W`=32
  - `RAS_DEPTH_DEF`=8
  - `typedef logic [WORD_W-1:0] addr_t`
- Sub-module `ras_mem`: DEPTH×AW register array with a synchronous write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr`, `rdata`). It has no reset.
- `ras_ctrl` holds the pointers, count, bypass mux, output registers and flag logic.

## Test plan
- Reset, then push 0x0040_0008, 0x0040_0010, 0x0040_0018 on consecutive cycles → `count` 1,2,3; `top_addr` follows each value; then 3 pops → `top_addr` 0x0040_0010, then 0x0040_0008, then `top_valid`=0 and `count`=0.
- Push 9 distinct values with DEPTH=8 → `overflow` pulses once, on the 9th; `count`=8; 8 pops return values 9..2; a 9th pop → `underflow` pulse, `count` stays 0.
- With `count`=2 and top 0xA, assert push 0xB & pop together → `count`=2, `top_addr`=0xB; one pop → `top_addr` = the original bottom entry.
- Push and pop together with `count`=0 → `count`=1, `top_addr`=`push_addr`, no `underflow`.
- `flush` together with push, at `count`=5 → `count`=0, `top_valid`=0, no flags; the next push gives `count`=1.
- Assert `rst_n`=0 asynchronously between edges at `count`=4 → outputs zero immediately, before the next edge; after release, a push of 0x1234 appears on `top_addr` one cycle later.
